// File: rtl/sc_speedcounter.sv
// rtl/sc_speedcounter.sv - level-programmable up-counter with active-low wrap tick
// The level shrinks the terminal count by halving BASELIMIT once per level (0..3).
module sc_speedcounter #(
    parameter int                                SPEEDCOUNTER_DATAWIDTH = 23,
    parameter logic [SPEEDCOUNTER_DATAWIDTH-1:0] SPEEDCOUNTER_BASELIMIT = 23'h7FFFFF
) (
    input  logic                              SC_SPEEDCOUNTER_CLOCK_50,
    input  logic                              SC_SPEEDCOUNTER_RESET_InHigh,
    input  logic                              SC_SPEEDCOUNTER_run_InHigh,
    input  logic                              SC_SPEEDCOUNTER_levelup_InLow,
    input  logic                              SC_SPEEDCOUNTER_clear_InLow,
    output logic [SPEEDCOUNTER_DATAWIDTH-1:0] SC_SPEEDCOUNTER_data_OutBUS,
    output logic                              SC_SPEEDCOUNTER_T0_OutLow,
    output logic [1:0]                        SC_SPEEDCOUNTER_level_OutBUS,
    output logic                              SC_SPEEDCOUNTER_maxlevel_OutHigh
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        HOLD  = 2'd2
    } stateT;

    stateT                             state, stateNext;
    logic [SPEEDCOUNTER_DATAWIDTH-1:0] count, countNext;
    logic [1:0]                        level, levelNext;
    logic                              t0, t0Next;
    logic                              levelupPrev;

    logic [SPEEDCOUNTER_DATAWIDTH-1:0] limit;
    logic [SPEEDCOUNTER_DATAWIDTH-1:0] raisedLimit;
    logic [1:0]                        levelRaised;
    logic                              levelInc;
    logic                              counting;

    assign limit       = SPEEDCOUNTER_BASELIMIT >> level;
    assign levelRaised = level + 2'd1;
    assign raisedLimit = SPEEDCOUNTER_BASELIMIT >> levelRaised;
    assign levelInc    = levelupPrev & ~SC_SPEEDCOUNTER_levelup_InLow & (level != 2'd3);
    // Leaving HOLD counts on the same edge, so HOLD with run behaves like COUNT.
    assign counting    = SC_SPEEDCOUNTER_run_InHigh & (state != IDLE);

    always_comb begin
        stateNext = state;
        countNext = count;
        levelNext = level;
        t0Next    = 1'b1;

        case (state)
            IDLE:    if (SC_SPEEDCOUNTER_run_InHigh)  stateNext = COUNT;
            COUNT:   if (!SC_SPEEDCOUNTER_run_InHigh) stateNext = HOLD;
            HOLD:    if (SC_SPEEDCOUNTER_run_InHigh)  stateNext = COUNT;
            default: stateNext = IDLE;
        endcase

        if (levelInc) begin
            levelNext = levelRaised;
        end

        // Wrap is judged against the old limit; a shrink only matters without a wrap.
        if (!SC_SPEEDCOUNTER_clear_InLow) begin
            countNext = '0;
            levelNext = 2'd0;
            stateNext = IDLE;
        end else if (counting && (count == limit)) begin
            countNext = '0;
            t0Next    = 1'b0;
        end else if (levelInc && (raisedLimit < count)) begin
            countNext = '0;
        end else if (counting) begin
            countNext = count + 1'b1;
        end
    end

    always_ff @(posedge SC_SPEEDCOUNTER_CLOCK_50) begin
        if (SC_SPEEDCOUNTER_RESET_InHigh) begin
            state       <= IDLE;
            count       <= '0;
            level       <= 2'd0;
            t0          <= 1'b1;
            levelupPrev <= 1'b1;
        end else begin
            state       <= stateNext;
            count       <= countNext;
            level       <= levelNext;
            t0          <= t0Next;
            levelupPrev <= SC_SPEEDCOUNTER_levelup_InLow;
        end
    end

    assign SC_SPEEDCOUNTER_data_OutBUS      = count;
    assign SC_SPEEDCOUNTER_T0_OutLow        = t0;
    assign SC_SPEEDCOUNTER_level_OutBUS     = level;
    assign SC_SPEEDCOUNTER_maxlevel_OutHigh = (level == 2'd3);

endmodule

// File: tb/tb_sc_speedcounter.sv
// tb/tb_sc_speedcounter.sv - directed table, free-run sequence and random model check
module tb_sc_speedcounter;

    localparam int DW = 8;
    localparam int BASE = 15;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          run = 1'b0;
    logic          lu = 1'b1;
    logic          clr = 1'b1;
    logic [DW-1:0] data;
    logic          t0;
    logic [1:0]    lvl;
    logic          maxl;

    int nChecks = 0;
    int nFails = 0;

    always #5 clk = ~clk;

    sc_speedcounter #(
        .SPEEDCOUNTER_DATAWIDTH(DW),
        .SPEEDCOUNTER_BASELIMIT(8'd15)
    ) dut (
        .SC_SPEEDCOUNTER_CLOCK_50        (clk),
        .SC_SPEEDCOUNTER_RESET_InHigh    (rst),
        .SC_SPEEDCOUNTER_run_InHigh      (run),
        .SC_SPEEDCOUNTER_levelup_InLow   (lu),
        .SC_SPEEDCOUNTER_clear_InLow     (clr),
        .SC_SPEEDCOUNTER_data_OutBUS     (data),
        .SC_SPEEDCOUNTER_T0_OutLow       (t0),
        .SC_SPEEDCOUNTER_level_OutBUS    (lvl),
        .SC_SPEEDCOUNTER_maxlevel_OutHigh(maxl)
    );

    typedef struct {
        logic rst, run, lu, clr;
        int   expData;
        logic expT0;
        int   expLvl;
        logic expMax;
    } vecT;

    vecT vecs[$];

    function automatic void add(logic r, logic rn, logic l, logic c, int d, logic t, int lv, logic m);
        vecT v;
        v.rst = r; v.run = rn; v.lu = l; v.clr = c;
        v.expData = d; v.expT0 = t; v.expLvl = lv; v.expMax = m;
        vecs.push_back(v);
    endfunction

    task automatic stepCheck(input string name, input int idx, input logic r, input logic rn,
                             input logic l, input logic c, input int d, input logic t,
                             input int lv, input logic m);
        @(negedge clk);
        rst = r; run = rn; lu = l; clr = c;
        @(posedge clk);
        #1;
        nChecks++;
        if (int'(data) != d || t0 !== t || int'(lvl) != lv || maxl !== m) begin
            nFails++;
            $display("FAIL %s step %0d: got data=%0d t0=%b level=%0d max=%b, expected data=%0d t0=%b level=%0d max=%b",
                     name, idx, data, t0, lvl, maxl, d, t, lv, m);
        end
    endtask

    // Behavioural reference: "started" means run has been seen since the last reset/clear.
    int   mCount, mLevel, mStarted, mPrev;
    logic mT0;

    function automatic int limitOf(int level);
        return BASE / (2 ** level);
    endfunction

    function automatic void modelStep(logic r, logic rn, logic l, logic c);
        bit fall;
        int newLevel;
        if (r) begin
            mCount = 0; mLevel = 0; mStarted = 0; mPrev = 1; mT0 = 1'b1;
            return;
        end
        fall = (mPrev == 1) && (l == 1'b0);
        mPrev = int'(l);
        mT0 = 1'b1;
        if (!c) begin
            mCount = 0; mLevel = 0; mStarted = 0;
            return;
        end
        newLevel = (fall && mLevel < 3) ? mLevel + 1 : mLevel;
        if (mStarted == 0) begin
            if (rn) mStarted = 1;
        end else if (rn && mCount == limitOf(mLevel)) begin
            mCount = 0;
            mT0 = 1'b0;
        end else if (newLevel != mLevel && limitOf(newLevel) < mCount) begin
            mCount = 0;
        end else if (rn) begin
            mCount = mCount + 1;
        end
        mLevel = newLevel;
    endfunction

    initial begin
        int ticks;
        int expD;

        // reset and start latency
        add(1,0,1,1, 0,1,0,0); add(1,0,1,1, 0,1,0,0);
        add(0,0,1,1, 0,1,0,0); add(0,0,1,1, 0,1,0,0);
        add(0,1,1,1, 0,1,0,0);
        for (int i = 1; i <= 5; i++) add(0,1,1,1, i,1,0,0);
        // hold at 5, resume to 6 on the first edge with run
        for (int i = 0; i < 10; i++) add(0,0,1,1, 5,1,0,0);
        add(0,1,1,1, 6,1,0,0);
        // level-up without shrink, then wrap against the new limit 7
        add(0,1,0,1, 7,1,1,0);
        add(0,1,0,1, 0,0,1,0);
        for (int i = 1; i <= 7; i++) add(0,1,1,1, i,1,1,0);
        // level-up on the wrap edge
        add(0,1,0,1, 0,0,2,0);
        for (int i = 1; i <= 3; i++) add(0,1,1,1, i,1,2,0);
        // clear at data 3, level 2 (also the wrap point): no tick
        add(0,1,1,0, 0,1,0,0);
        add(0,1,1,1, 0,1,0,0);
        for (int i = 1; i <= 10; i++) add(0,1,1,1, i,1,0,0);
        // shrink at 10: level 1, count zeroed without tick, ticks every 8
        add(0,1,0,1, 0,1,1,0);
        for (int i = 1; i <= 7; i++) add(0,1,1,1, i,1,1,0);
        add(0,1,1,1, 0,0,1,0);
        for (int i = 1; i <= 7; i++) add(0,1,1,1, i,1,1,0);
        // clear coincident with wrap
        add(0,1,1,0, 0,1,0,0);
        add(0,0,1,1, 0,1,0,0);
        // levelup held low 5 cycles: one increment
        for (int i = 0; i < 5; i++) add(0,0,0,1, 0,1,1,0);
        add(0,0,1,1, 0,1,1,0);
        add(0,0,0,1, 0,1,2,0); add(0,0,1,1, 0,1,2,0);
        add(0,0,0,1, 0,1,3,1); add(0,0,1,1, 0,1,3,1);
        add(0,0,0,1, 0,1,3,1); add(0,0,1,1, 0,1,3,1);
        // level 3: tick every 2 cycles
        add(0,1,1,1, 0,1,3,1); add(0,1,1,1, 1,1,3,1);
        for (int k = 0; k < 3; k++) begin
            add(0,1,1,1, 0,0,3,1); add(0,1,1,1, 1,1,3,1);
        end
        // reset with a tick pending, then stay idle
        add(1,1,1,1, 0,1,0,0); add(1,1,1,1, 0,1,0,0);
        add(0,0,1,1, 0,1,0,0); add(0,0,1,1, 0,1,0,0);

        for (int i = 0; i < vecs.size(); i++)
            stepCheck("table", i, vecs[i].rst, vecs[i].run, vecs[i].lu, vecs[i].clr,
                      vecs[i].expData, vecs[i].expT0, vecs[i].expLvl, vecs[i].expMax);

        // free run over three periods at level 0
        stepCheck("freerun_start", 0, 0,1,1,1, 0,1,0,0);
        ticks = 0;
        for (int i = 0; i < 48; i++) begin
            expD = (i + 1) % 16;
            stepCheck("freerun", i, 0,1,1,1, expD, (expD == 0) ? 1'b0 : 1'b1, 0,0);
            if (t0 === 1'b0) ticks++;
        end
        nChecks++;
        if (ticks != 3) begin
            nFails++;
            $display("FAIL freerun_ticks: got %0d ticks, expected 3", ticks);
        end

        // randomized traffic against the reference model
        modelStep(1'b1, 1'b0, 1'b1, 1'b1);
        stepCheck("rand_reset", 0, 1,0,1,1, mCount, mT0, mLevel, mLevel == 3);
        for (int i = 0; i < 3000; i++) begin
            logic r, rn, l, c;
            r  = ($urandom_range(0, 99) == 0);
            c  = ($urandom_range(0, 39) != 0);
            rn = ($urandom_range(0, 3) != 0);
            l  = ($urandom_range(0, 5) != 0);
            modelStep(r, rn, l, c);
            stepCheck("random", i, r, rn, l, c, mCount, mT0, mLevel, mLevel == 3);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
